// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler
//   Owns the 4-digit multiplexed seven-segment display and its four push-buttons.
//   Each button is synchronized and debounced. A debounced press latches switch_i
//   into that button's digit register. A scan FSM (OFF/BLANK/SHOW) time-shares the
//   cathode bus across the anodes and inserts a dark interval at the start of
//   every slot to stop ghosting.
// Ports:
//   clk_i          system clock
//   reset_i        synchronous active-high reset
//   enable_i       1 = scan the display, 0 = display dark
//   switch_i[3:0]  value loaded into a digit on a press
//   btn_i[3:0]     raw asynchronous buttons, btn_i[i] loads digit i
//   anodes_o[3:0]  active-low digit select (digit 0 = 0111 ... digit 3 = 1110)
//   cathodes_o[6:0] active-low segments {a,b,c,d,e,f,g}
//   digit_valid_o  bit i set once digit i has been loaded
//   scan_idx_o     digit slot currently being scanned
module seg_display_scheduler #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned BLANK    = 50,
    parameter int unsigned DEBOUNCE = 20000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic [3:0] switch_i,
    input  logic [3:0] btn_i,
    output logic [3:0] anodes_o,
    output logic [6:0] cathodes_o,
    output logic [3:0] digit_valid_o,
    output logic [1:0] scan_idx_o
);

    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DW = $clog2(DEBOUNCE + 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_LAST = SW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE);

    typedef enum logic [1:0] {S_OFF, S_BLANK, S_SHOW} state_t;

    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    db_q, db_d;
    logic [DW-1:0] dcnt_q [4];
    logic [DW-1:0] dcnt_d [4];
    logic [3:0]    digit_q [4];
    logic [3:0]    digit_d [4];
    logic [3:0]    valid_q, valid_d;

    state_t        state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    anodes_q, anodes_d;
    logic [6:0]    cathodes_q, cathodes_d;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b0000001;
            4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;
            4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;
            4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;
            4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0000010;
            4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;
            4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0010000;
            4'hF: hex7 = 7'b0111000;
            default: hex7 = 7'b1111111;
        endcase
    endfunction

    // Debounce: the counter runs while the synchronized level disagrees with the
    // accepted level; a rising accept is the load strobe for that digit.
    always_comb begin
        db_d    = db_q;
        valid_d = valid_q;
        digit_d = digit_q;
        for (int unsigned i = 0; i < 4; i++) begin
            dcnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (dcnt_q[i] == DB_LAST) begin
                    db_d[i] = sync2_q[i];
                    if (sync2_q[i]) begin
                        digit_d[i] = switch_i;
                        valid_d[i] = 1'b1;
                    end
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DW'(1);
                end
            end
        end
    end

    // Scan FSM next state. The slot counter keeps running from BLANK into SHOW so
    // a slot is always SCAN_DIV cycles long.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        idx_d   = idx_q;
        case (state_q)
            S_OFF: begin
                slot_d = '0;
                if (enable_i) begin
                    idx_d   = '0;
                    state_d = (BLANK == 0) ? S_SHOW : S_BLANK;
                end
            end
            S_BLANK: begin
                slot_d = slot_q + SW'(1);
                if (slot_q == BLANK_LAST) state_d = S_SHOW;
            end
            S_SHOW: begin
                if (slot_q == SLOT_LAST) begin
                    slot_d  = '0;
                    idx_d   = idx_q + 2'd1;
                    state_d = (BLANK == 0) ? S_SHOW : S_BLANK;
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
            default: state_d = S_OFF;
        endcase
        if (!enable_i) state_d = S_OFF;
    end

    // Outputs are registered from the next state; cathodes use the digit contents
    // before this edge, so a load shows up one edge after it lands.
    always_comb begin
        anodes_d   = '1;
        cathodes_d = '1;
        if (state_d == S_SHOW) begin
            anodes_d = ~(4'b1000 >> idx_d);
            if (valid_q[idx_d]) cathodes_d = hex7(digit_q[idx_d]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_q       <= '0;
            dcnt_q     <= '{default: '0};
            digit_q    <= '{default: '0};
            valid_q    <= '0;
            state_q    <= S_OFF;
            slot_q     <= '0;
            idx_q      <= '0;
            anodes_q   <= '1;
            cathodes_q <= '1;
        end else begin
            sync1_q    <= btn_i;
            sync2_q    <= sync1_q;
            db_q       <= db_d;
            dcnt_q     <= dcnt_d;
            digit_q    <= digit_d;
            valid_q    <= valid_d;
            state_q    <= state_d;
            slot_q     <= slot_d;
            idx_q      <= idx_d;
            anodes_q   <= anodes_d;
            cathodes_q <= cathodes_d;
        end
    end

    assign anodes_o      = anodes_q;
    assign cathodes_o    = cathodes_q;
    assign digit_valid_o = valid_q;
    assign scan_idx_o    = idx_q;

endmodule

// File: doc/seg_display_scheduler.md
# seg_display_scheduler

Controller that owns the board's 4-digit multiplexed seven-segment display and the four push-buttons feeding it. Debounces each button; on a debounced press, latches the 4-bit switch value into that button's digit register. A scan state machine time-shares the common cathode bus across the four anodes, inserting a blanking interval between digits to prevent ghosting. Sits between the board I/O pins and the switch/LED logic, and replaces ad-hoc button sampling and free-running scan clocks with one single-clock, synchronously reset block.

## Interface
- SCAN_DIV, 1000: clk cycles per digit slot; must be ≥ BLANK+1.
- BLANK, 50: cycles at the start of each slot with all anodes off; 0 disables blanking.
- DEBOUNCE, 20000: consecutive stable cycles needed to accept a button level change; must be ≥ 1.
- clk  in  1  system clock; every register is updated on posedge clk.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = scan the display; 0 = display dark.
- switch  in  4  value loaded into a digit on a press.
- btn  in  4  raw asynchronous buttons; btn[i] loads digit i.
- anodes  out  4  active-low digit select. Digit 0 = 0111, 1 = 1011, 2 = 1101, 3 = 1110.
- cathodes  out  7  active-low segments {a,b,c,d,e,f,g}.
- digit_valid  out  4  bit i set once digit i has been loaded.
- scan_idx  out  2  digit slot currently being scanned.

## Operation
- Reset: digits = 0, digit_valid = 0000, scan state OFF, scan_idx = 0, slot counter = 0, debounce state cleared, anodes = 1111, cathodes = 1111111.
- Button path, per bit:
  - The raw button passes through a 2-flop synchronizer.
  - A counter counts cycles while the synchronized level differs from the debounced level, and clears when they match.
  - When the count reaches DEBOUNCE, the debounced level flips and the counter clears.
  - A 0→1 transition of the debounced level is a load: digit[i] ← switch and digit_valid[i] ← 1 on the same edge.
  - A 1→0 transition has no effect.
- Simultaneous loads on several buttons are all accepted in the same cycle, each taking the current switch value. Loads are accepted regardless of enable.
- Scan FSM states: OFF, BLANK, SHOW.
  - OFF: anodes = 1111, cathodes = 1111111. Moves to BLANK with scan_idx = 0 and slot counter = 0 when enable = 1.
  - BLANK: anodes = 1111, cathodes = 1111111. Moves to SHOW when slot counter = BLANK−1. If BLANK = 0, this state is skipped.
  - SHOW: anode for scan_idx active. cathodes = hex decode of digit[scan_idx] if digit_valid[scan_idx] = 1, else 1111111. At slot counter = SCAN_DIV−1, the counter clears, scan_idx increments (wrapping 3→0) and the FSM moves to BLANK.
  - From any state, enable = 0 forces OFF on the next edge.
- Hex decode, cathodes by value: 0:0000001, 1:1001111, 2:0010010, 3:0000110, 4:1001100, 5:0100100, 6:0100000, 7:0001111, 8:0000000, 9:0000100, A:0000010, b:1100000, C:0110001, d:1000010, E:0010000, F:0111000.
- A load that lands during SHOW of the same digit updates cathodes on the following edge.

## Timing
- All outputs are registered. anodes and cathodes reflect the state and counter values after the current edge.
- Load latency: btn held high and first sampled at edge N → digit and digit_valid updated at edge N+DEBOUNCE+2. A pulse shorter than DEBOUNCE+1 sampled cycles never loads.
- Scan period = 4×SCAN_DIV cycles. Each slot = BLANK cycles dark followed by SCAN_DIV−BLANK cycles lit.
- enable 1→0 sampled at edge E → anodes = 1111 after E.
- enable 0→1 sampled at edge E → BLANK slot 0 starts after E. First lit cycle is after edge E+BLANK.
- reset has priority over all other inputs. Asserting it mid-slot or mid-debounce restores reset values on the next edge. Digit contents are lost.

## Test plan
Use SCAN_DIV=8, BLANK=2, DEBOUNCE=4.
- Reset check: assert reset with btn and enable toggling → anodes=1111, cathodes=1111111, digit_valid=0000, scan_idx=0 throughout reset and on the first cycle after it.
- Single load and display: enable=1, switch=A, btn=0001 held → digit_valid=0001 at edge N+6. In slot 0 SHOW: anodes=0111, cathodes=0000010. Slots 1–3: anodes lit, cathodes=1111111.
- Bounce rejection: btn[1] high for 3 cycles, low 2, high 3, then low → digit_valid stays 0000. Holding high ≥5 cycles → bit 1 set.
- Scan timing: enable rises at edge E → anodes 1111 for 2 cycles, then 0111 for 6, 1111 for 2, 1011 for 6, and so on. scan_idx wraps 3→0 after 32 cycles.
- Enable drop and restart: deassert enable mid-SHOW of slot 2 → anodes=1111 next cycle. Re-enable → BLANK with scan_idx=0. Digits are retained.
- Simultaneous press: switch=5, btn=1100 held → digit_valid=1100, both digits show 0100100 in their slots. Press btn[2] again with switch=3 while slot 2 is lit → cathodes=0000110 on the next cycle.
